// File: rtl/dq_burst_deser.sv
// dq_burst_deser
//   Deserialises BL beats of an arch-lane DQ bus into one WIDTH-bit burst word.
//   Completed bursts are queued in a 2-entry FIFO with a registered head.
//
// Ports
//   mem_clk     : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   DQ          : one bit per lane per beat
//   dq_valid    : DQ carries a beat this cycle
//   SerDes_en   : capture enable; dropping it aborts a partial burst
//   err_clr     : synchronous clear of the sticky error flags
//   rdata       : head-of-queue burst word
//   rdata_valid : rdata holds a burst
//   rdata_ready : consumer accepts rdata
//   status      : high while a burst is being captured
//   overflow    : sticky, a completed burst was dropped (queue full)
//   gap_err     : sticky, a burst was aborted by a gap timeout
module dq_burst_deser #(
    parameter int WIDTH   = 32,
    parameter int arch    = 16,
    parameter int BL      = WIDTH / arch,
    parameter int GAP_MAX = 4
) (
    input  logic             mem_clk,
    input  logic             rst_n,
    input  logic [arch-1:0]  DQ,
    input  logic             dq_valid,
    input  logic             SerDes_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic             status,
    output logic             overflow,
    output logic             gap_err
);

    localparam int CNT_W = (BL > 1) ? $clog2(BL) : 1;
    localparam int GAP_W = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BL - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [WIDTH-1:0] asm_word;
    logic [WIDTH-1:0] merged;

    logic [WIDTH-1:0] head_data, tail_data;
    logic             head_vld, tail_vld;

    logic beat_ok, burst_done, gap_timeout, pop, push_ok, push_drop;

    // A beat is taken whenever capture is enabled; in IDLE beat_cnt is 0, so
    // the same path stores beat 0 and later beats.
    assign beat_ok     = SerDes_en && dq_valid;
    assign burst_done  = beat_ok && (beat_cnt == CNT_LAST);
    assign gap_timeout = (state == CAPTURE) && SerDes_en && !dq_valid && (gap_cnt == GAP_LAST);

    assign pop       = head_vld && rdata_ready;
    assign push_ok   = burst_done && (!tail_vld || pop);
    assign push_drop = burst_done && tail_vld && !pop;

    // Current beat merged into the partial word: lane i, beat k -> bit BL*i+k.
    always_comb begin
        merged = asm_word;
        for (int i = 0; i < arch; i++) begin
            for (int k = 0; k < BL; k++) begin
                if (beat_cnt == CNT_W'(k)) begin
                    merged[i*BL + k] = DQ[i];
                end
            end
        end
    end

    // Partial-burst data needs no reset: every bit is rewritten before use.
    always_ff @(posedge mem_clk) begin
        if (beat_ok) begin
            asm_word <= merged;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat_ok) begin
                        gap_cnt <= '0;
                        if (burst_done) begin
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= CAPTURE;
                        end
                    end
                end
                default: begin
                    if (!SerDes_en || burst_done || gap_timeout) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        gap_cnt  <= '0;
                    end else if (beat_ok) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt  <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Two-entry queue: head feeds rdata directly, tail backs it up.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_vld  <= 1'b0;
            tail_vld  <= 1'b0;
        end else begin
            if (pop) begin
                if (tail_vld) begin
                    head_data <= tail_data;
                    tail_vld  <= push_ok;
                end else if (push_ok) begin
                    head_data <= merged;
                end else begin
                    head_vld  <= 1'b0;
                end
            end else if (push_ok) begin
                if (!head_vld) begin
                    head_data <= merged;
                    head_vld  <= 1'b1;
                end else begin
                    tail_vld  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (push_ok && (head_vld && !(pop && !tail_vld))) begin
            tail_data <= merged;
        end
    end

    // Sticky flags: a set event in the same cycle wins over err_clr.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            gap_err  <= 1'b0;
        end else begin
            if (push_drop)    overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (gap_timeout)  gap_err  <= 1'b1;
            else if (err_clr) gap_err  <= 1'b0;
        end
    end

    assign rdata       = head_data;
    assign rdata_valid = head_vld;
    assign status      = (state == CAPTURE);

endmodule

// File: tb/tb_dq_burst_deser.sv
// tb_dq_burst_deser
//   Directed bench for dq_burst_deser at WIDTH=32, arch=16 (BL=2), GAP_MAX=4.
//   A vector table covers capture, gap handling and flags; hand-written
//   sequences cover queue back-pressure, overflow and mid-burst reset.
module tb_dq_burst_deser;

    logic        mem_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] DQ = '0;
    logic        dq_valid = 1'b0;
    logic        SerDes_en = 1'b0;
    logic        err_clr = 1'b0;
    logic        rdata_ready = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        status;
    logic        overflow;
    logic        gap_err;

    int passed = 0;
    int total  = 0;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    typedef struct packed {
        logic        en;
        logic        vld;
        logic [15:0] dq;
        logic        rdy;
        logic        clr;
        logic        st;
        logic        rv;
        logic [31:0] rd;
        logic        ov;
        logic        ge;
    } vec_t;

    vec_t vecs [0:28];

    dq_burst_deser #(.WIDTH(32), .arch(16), .GAP_MAX(4)) dut (
        .mem_clk     (mem_clk),
        .rst_n       (rst_n),
        .DQ          (DQ),
        .dq_valid    (dq_valid),
        .SerDes_en   (SerDes_en),
        .err_clr     (err_clr),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .status      (status),
        .overflow    (overflow),
        .gap_err     (gap_err)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic en, input logic vld, input logic [15:0] d,
                         input logic rdy, input logic clr);
        SerDes_en   = en;
        dq_valid    = vld;
        DQ          = d;
        rdata_ready = rdy;
        err_clr     = clr;
        @(posedge mem_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rdata"},       rdata, 32'h0);
        check({tag, " rdata_valid"}, 32'(rdata_valid), 32'h0);
        check({tag, " status"},      32'(status), 32'h0);
        check({tag, " overflow"},    32'(overflow), 32'h0);
        check({tag, " gap_err"},     32'(gap_err), 32'h0);
    endtask

    initial begin
        //          en vld dq        rdy clr st rv rd            ov ge
        vecs[0]  = '{H, L, 16'h0000, H, L, L, L, 32'h00000000, L, L};
        vecs[1]  = '{H, H, 16'hFFFF, H, L, H, L, 32'h00000000, L, L};
        vecs[2]  = '{H, H, 16'h0000, H, L, L, H, 32'h55555555, L, L};
        vecs[3]  = '{H, L, 16'h0000, H, L, L, L, 32'h00000000, L, L};
        vecs[4]  = '{H, H, 16'h0001, H, L, H, L, 32'h00000000, L, L};
        vecs[5]  = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[6]  = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[7]  = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[8]  = '{H, H, 16'h0001, H, L, L, H, 32'h00000003, L, L};
        vecs[9]  = '{H, L, 16'h0000, H, L, L, L, 32'h00000000, L, L};
        vecs[10] = '{H, H, 16'h1234, H, L, H, L, 32'h00000000, L, L};
        vecs[11] = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[12] = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[13] = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[14] = '{H, L, 16'h0000, H, L, L, L, 32'h00000000, L, H};
        vecs[15] = '{H, L, 16'h0000, H, L, L, L, 32'h00000000, L, H};
        vecs[16] = '{H, L, 16'h0000, H, H, L, L, 32'h00000000, L, L};
        vecs[17] = '{H, H, 16'hFFFF, H, L, H, L, 32'h00000000, L, L};
        vecs[18] = '{L, H, 16'hFFFF, H, L, L, L, 32'h00000000, L, L};
        vecs[19] = '{L, H, 16'hFFFF, H, L, L, L, 32'h00000000, L, L};
        vecs[20] = '{H, H, 16'h00FF, H, L, H, L, 32'h00000000, L, L};
        vecs[21] = '{H, H, 16'hFF00, H, L, L, H, 32'hAAAA5555, L, L};
        vecs[22] = '{H, L, 16'h0000, H, L, L, L, 32'h00000000, L, L};
        vecs[23] = '{H, H, 16'h0001, H, L, H, L, 32'h00000000, L, L};
        vecs[24] = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[25] = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[26] = '{H, L, 16'h0000, H, L, H, L, 32'h00000000, L, L};
        vecs[27] = '{H, L, 16'h0000, H, H, L, L, 32'h00000000, L, H};
        vecs[28] = '{H, L, 16'h0000, H, H, L, L, 32'h00000000, L, L};

        // Reset state
        drive(L, L, 16'h0000, L, L);
        drive(L, L, 16'h0000, L, L);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Table-driven vectors: inputs before an edge, outputs after it
        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].en, vecs[i].vld, vecs[i].dq, vecs[i].rdy, vecs[i].clr);
            check($sformatf("row%0d status", i),      32'(status),      32'(vecs[i].st));
            check($sformatf("row%0d rdata_valid", i), 32'(rdata_valid), 32'(vecs[i].rv));
            check($sformatf("row%0d overflow", i),    32'(overflow),    32'(vecs[i].ov));
            check($sformatf("row%0d gap_err", i),     32'(gap_err),     32'(vecs[i].ge));
            if (vecs[i].rv) check($sformatf("row%0d rdata", i), rdata, vecs[i].rd);
        end

        // Back-pressure: A, B queued, C dropped
        drive(H, H, 16'h0001, L, L);
        drive(H, H, 16'h0000, L, L);
        check("ovf A valid", 32'(rdata_valid), 32'h1);
        check("ovf A data", rdata, 32'h00000001);
        drive(H, H, 16'h0000, L, L);
        drive(H, H, 16'h0001, L, L);
        check("ovf hold A", rdata, 32'h00000001);
        check("ovf no flag yet", 32'(overflow), 32'h0);
        drive(H, H, 16'h0001, L, L);
        drive(H, H, 16'h0001, L, L);
        check("ovf C dropped flag", 32'(overflow), 32'h1);
        check("ovf hold A after C", rdata, 32'h00000001);
        drive(L, L, 16'h0000, H, L);
        check("ovf B valid", 32'(rdata_valid), 32'h1);
        check("ovf B data", rdata, 32'h00000002);
        drive(L, L, 16'h0000, H, L);
        check("ovf drained", 32'(rdata_valid), 32'h0);
        check("ovf sticky", 32'(overflow), 32'h1);
        drive(L, L, 16'h0000, L, H);
        check("ovf cleared", 32'(overflow), 32'h0);

        // Push and pop on the same edge with the queue full
        drive(H, H, 16'h0001, L, L);
        drive(H, H, 16'h0000, L, L);
        drive(H, H, 16'h0000, L, L);
        drive(H, H, 16'h0001, L, L);
        drive(H, H, 16'h0001, L, L);
        drive(H, H, 16'h0001, H, L);
        check("full push+pop overflow", 32'(overflow), 32'h0);
        check("full push+pop head B", rdata, 32'h00000002);
        drive(L, L, 16'h0000, H, L);
        check("full push+pop C valid", 32'(rdata_valid), 32'h1);
        check("full push+pop C data", rdata, 32'h00000003);
        drive(L, L, 16'h0000, H, L);
        check("full push+pop drained", 32'(rdata_valid), 32'h0);

        // Mid-burst reset with a burst waiting in the queue
        drive(H, H, 16'hFFFF, L, L);
        drive(H, H, 16'h0000, L, L);
        drive(H, H, 16'hFFFF, L, L);
        check("pre-reset status", 32'(status), 32'h1);
        check("pre-reset queued", 32'(rdata_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge mem_clk);
        #1;
        rst_n = 1'b1;
        drive(H, H, 16'h0000, H, L);
        check("post-reset beat0 status", 32'(status), 32'h1);
        drive(H, H, 16'hFFFF, H, L);
        check("post-reset valid", 32'(rdata_valid), 32'h1);
        check("post-reset data", rdata, 32'hAAAAAAAA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dq_burst_deser.md
DQ_BURST_DESER -- requirements
Module: dq_burst_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the assembled burst word width in bits.
REQ-002 The block SHALL have parameter arch, default 16, meaning the number of DQ lanes.
REQ-003 The block SHALL have parameter BL, default WIDTH/arch, meaning beats per burst (legal: BL >= 1).
REQ-004 The block SHALL have parameter GAP_MAX, default 4, meaning the maximum idle cycles allowed between beats inside a burst.
REQ-005 The block SHALL have port mem_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port DQ, input, arch bits: one data bit per lane per beat.
REQ-008 The block SHALL have port dq_valid, input, 1 bit: DQ carries a valid beat this cycle.
REQ-009 The block SHALL have port SerDes_en, input, 1 bit: capture enable.
REQ-010 The block SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port rdata, output, WIDTH bits: head-of-queue assembled burst.
REQ-012 The block SHALL have port rdata_valid, output, 1 bit: rdata is valid.
REQ-013 The block SHALL have port rdata_ready, input, 1 bit: consumer accepts rdata.
REQ-014 The block SHALL have port status, output, 1 bit: high while a burst is being captured.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky, a completed burst was dropped because the queue was full.
REQ-016 The block SHALL have port gap_err, output, 1 bit: sticky, a burst was aborted by a gap timeout.

Function
REQ-017 Bit mapping: beat k (k = 0 first received) of lane i SHALL land in rdata[BL*i+k].
REQ-018 The FSM SHALL have two states, IDLE and CAPTURE; status SHALL be 1 exactly in CAPTURE.
REQ-019 In IDLE, with SerDes_en=1 and dq_valid=1, the block SHALL store beat 0; if BL=1 the burst completes that cycle and the FSM stays in IDLE, otherwise the FSM enters CAPTURE with beat count 1.
REQ-020 In IDLE, a dq_valid with SerDes_en=0 SHALL be ignored.
REQ-021 In CAPTURE, each dq_valid=1 cycle SHALL store the beat at the current count and increment the count; the beat at count BL-1 completes the burst and returns the FSM to IDLE.
REQ-022 In CAPTURE, a dq_valid=0 cycle SHALL increment a gap counter (cleared on each beat); when the gap counter reaches GAP_MAX, the partial burst SHALL be discarded, gap_err set, and the FSM returns to IDLE.
REQ-023 In CAPTURE, SerDes_en=0 SHALL discard the partial burst and return to IDLE without setting gap_err; this takes priority over any beat in the same cycle.
REQ-024 Completed bursts SHALL be pushed into a 2-entry FIFO; rdata/rdata_valid SHALL be driven from registered FIFO head state.
REQ-025 Latency: a burst completing on edge N SHALL present rdata_valid=1 after edge N when the FIFO was empty.
REQ-026 Handshake: an entry pops on an edge where rdata_valid=1 and rdata_ready=1; rdata SHALL hold stable while rdata_valid=1 and rdata_ready=0.
REQ-027 Push while the FIFO is full and no pop occurs SHALL drop the new burst, keep FIFO contents unchanged, and set overflow.
REQ-028 A simultaneous push and pop with the FIFO full SHALL accept the push (no overflow); with the FIFO empty, the pop is not possible and the push SHALL be accepted.
REQ-029 err_clr=1 SHALL clear overflow and gap_err on that edge; a set event in the same cycle SHALL take priority (the flag stays 1).

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously force: FSM to IDLE, beat and gap counters to 0, FIFO empty, rdata=0, rdata_valid=0, status=0, overflow=0, gap_err=0.
REQ-031 A reset asserted mid-burst SHALL discard the partial burst; after rst_n rises, the first beat accepted SHALL be treated as beat 0.

Verification
REQ-032 arch=16, BL=2: SerDes_en=1, DQ=16'hFFFF then 16'h0000 on consecutive dq_valid cycles -> next cycle rdata_valid=1, rdata=32'h55555555.
REQ-033 Beat 0 = 16'h0001, three dq_valid=0 cycles, beat 1 = 16'h0001 (GAP_MAX=4) -> rdata=32'h00000003, gap_err=0.
REQ-034 Beat 0, then dq_valid=0 for 4 cycles -> status falls, gap_err=1, no rdata_valid; err_clr pulse -> gap_err=0.
REQ-035 rdata_ready=0, three bursts A, B, C -> A then B delivered in order after ready rises, C dropped, overflow=1.
REQ-036 rst_n pulsed low after beat 0 -> all outputs 0 immediately; a subsequent 2-beat burst assembles correctly from beat 0.
